q_writeback_arbiter: RTL and testbench

Q_WRITEBACK_ARBITER -- requirements
Module: q_writeback_arbiter

---
 rtl/q_writeback_arbiter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_q_writeback_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_writeback_arbiter.sv
// Write-back arbiter: buffers single-bank Q-value writes in a FIFO and
// shares one memory port between draining them and 9-bank Q fetches.
module q_writeback_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        training_flag,
    input  logic [8:0]  en_ram,
    input  logic [17:0] state_plus1,
    input  logic [15:0] Q_new,
    input  logic        rd_req,
    input  logic [17:0] rd_state,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_bank,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] q_act1,
    output logic [15:0] q_act2,
    output logic [15:0] q_act3,
    output logic [15:0] q_act4,
    output logic [15:0] q_act5,
    output logic [15:0] q_act6,
    output logic [15:0] q_act7,
    output logic [15:0] q_act8,
    output logic [15:0] q_act9,
    output logic        rd_valid,
    output logic        rd_busy,
    output logic [2:0]  fifo_count,
    output logic [7:0]  drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t state;
    state_t state_d;

    logic [3:0]  fifo_bank [FIFO_DEPTH];
    logic [17:0] fifo_addr [FIFO_DEPTH];
    logic [15:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic        full;
    logic        empty;
    logic        one_hot;
    logic        multi_hot;
    logic [3:0]  cap_bank;
    logic        push;
    logic        pop;
    logic        drop;
    logic        ack;

    logic        pending;
    logic [17:0] rd_addr;
    logic [3:0]  rd_idx;
    logic [3:0]  idx_d;
    logic        clr_pend;
    logic        load_q;

    logic        req_d;
    logic        we_d;
    logic [3:0]  bank_d;
    logic [17:0] addr_d;
    logic [15:0] wdata_d;
    logic        valid_d;

    logic [15:0] q_act [1:9];

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign ack   = mem_ack && mem_req;

    // en_ram - 1 clears the lowest set bit, so a nonzero AND means 2+ bits.
    assign one_hot   = (en_ram != 9'd0) && ((en_ram & (en_ram - 9'd1)) == 9'd0);
    assign multi_hot = (en_ram != 9'd0) && !one_hot;

    always_comb begin
        cap_bank = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (en_ram[k]) begin
                cap_bank = 4'(k + 1);
            end
        end
    end

    assign push = training_flag && one_hot && !full;
    assign drop = training_flag && (multi_hot || (one_hot && full));

    always_comb begin
        state_d  = state;
        req_d    = 1'b0;
        we_d     = 1'b0;
        bank_d   = mem_bank;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        valid_d  = 1'b0;
        pop      = 1'b0;
        idx_d    = rd_idx;
        clr_pend = 1'b0;
        load_q   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    state_d = RD;
                    idx_d   = 4'd1;
                    req_d   = 1'b1;
                    bank_d  = 4'd1;
                    addr_d  = rd_addr;
                end else if (!empty) begin
                    state_d = WR;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    bank_d  = fifo_bank[rd_ptr];
                    addr_d  = fifo_addr[rd_ptr];
                    wdata_d = fifo_data[rd_ptr];
                end
            end
            WR: begin
                if (ack) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else begin
                    req_d = 1'b1;
                    we_d  = 1'b1;
                end
            end
            RD: begin
                if (ack) begin
                    load_q = 1'b1;
                    idx_d  = rd_idx + 4'd1;
                    if (rd_idx == 4'd9) begin
                        state_d = RDONE;
                        valid_d = 1'b1;
                    end else begin
                        req_d  = 1'b1;
                        bank_d = rd_idx + 4'd1;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            RDONE: begin
                state_d  = IDLE;
                clr_pend = 1'b1;
                idx_d    = 4'd1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state  <= IDLE;
            rd_idx <= 4'd1;
        end else begin
            state  <= state_d;
            rd_idx <= idx_d;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_bank  <= 4'd0;
            mem_addr  <= 18'd0;
            mem_wdata <= 16'd0;
            rd_valid  <= 1'b0;
        end else begin
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_bank  <= bank_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            rd_valid  <= valid_d;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_bank[wr_ptr] <= cap_bank;
            fifo_addr[wr_ptr] <= state_plus1;
            fifo_data[wr_ptr] <= Q_new;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // pending stays set through RDONE, so it doubles as rd_busy.
    always_ff @(posedge clock) begin
        if (rst) begin
            pending <= 1'b0;
            rd_addr <= 18'd0;
        end else if (clr_pend) begin
            pending <= 1'b0;
        end else if (rd_req && !pending) begin
            pending <= 1'b1;
            rd_addr <= rd_state;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int k = 1; k <= 9; k++) begin
                q_act[k] <= 16'd0;
            end
        end else if (load_q) begin
            q_act[rd_idx] <= mem_rdata;
        end
    end

    assign rd_busy    = pending;
    assign fifo_count = 3'(count);

    assign q_act1 = q_act[1];
    assign q_act2 = q_act[2];
    assign q_act3 = q_act[3];
    assign q_act4 = q_act[4];
    assign q_act5 = q_act[5];
    assign q_act6 = q_act[6];
    assign q_act7 = q_act[7];
    assign q_act8 = q_act[8];
    assign q_act9 = q_act[9];

endmodule

// File: tb/tb_q_writeback_arbiter.sv
// Directed bench for q_writeback_arbiter: write path, overflow, drops,
// read priority and mid-read reset, with hand-computed expectations.
module tb_q_writeback_arbiter;

    logic        clock = 1'b0;
    logic        rst;
    logic        training_flag;
    logic [8:0]  en_ram;
    logic [17:0] state_plus1;
    logic [15:0] Q_new;
    logic        rd_req;
    logic [17:0] rd_state;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_bank;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] q_act1, q_act2, q_act3, q_act4, q_act5;
    logic [15:0] q_act6, q_act7, q_act8, q_act9;
    logic        rd_valid;
    logic        rd_busy;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    q_writeback_arbiter #(.FIFO_DEPTH(4)) dut (
        .clock(clock), .rst(rst),
        .training_flag(training_flag), .en_ram(en_ram),
        .state_plus1(state_plus1), .Q_new(Q_new),
        .rd_req(rd_req), .rd_state(rd_state),
        .mem_req(mem_req), .mem_we(mem_we), .mem_bank(mem_bank),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .q_act1(q_act1), .q_act2(q_act2), .q_act3(q_act3),
        .q_act4(q_act4), .q_act5(q_act5), .q_act6(q_act6),
        .q_act7(q_act7), .q_act8(q_act8), .q_act9(q_act9),
        .rd_valid(rd_valid), .rd_busy(rd_busy),
        .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        training_flag = 1'b0;
        en_ram = 9'd0;
        state_plus1 = 18'd0;
        Q_new = 16'd0;
        rd_req = 1'b0;
        rd_state = 18'd0;
        mem_ack = 1'b0;
        mem_rdata = 16'd0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_bank", 32'(mem_bank), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_busy", 32'(rd_busy), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_q1", 32'(q_act1), 32'd0);

        // single write
        training_flag = 1'b1;
        en_ram = 9'b000010000;
        state_plus1 = 18'h00155;
        Q_new = 16'h0A00;
        tick();
        training_flag = 1'b0;
        en_ram = 9'd0;
        chk("w1_cnt", 32'(fifo_count), 32'd1);
        chk("w1_req0", 32'(mem_req), 32'd0);
        tick();
        chk("w1_req", 32'(mem_req), 32'd1);
        chk("w1_we", 32'(mem_we), 32'd1);
        chk("w1_bank", 32'(mem_bank), 32'd5);
        chk("w1_addr", 32'(mem_addr), 32'h155);
        chk("w1_wdata", 32'(mem_wdata), 32'h0A00);
        tick();
        chk("w1_hold", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("w1_ackreq", 32'(mem_req), 32'd0);
        chk("w1_ackcnt", 32'(fifo_count), 32'd0);

        // invalid enables
        training_flag = 1'b1;
        en_ram = 9'b000000011;
        tick();
        chk("inv_drop", 32'(drop_cnt), 32'd1);
        chk("inv_cnt", 32'(fifo_count), 32'd0);
        training_flag = 1'b0;
        tick();
        chk("inv_tf0_drop", 32'(drop_cnt), 32'd1);
        chk("inv_tf0_cnt", 32'(fifo_count), 32'd0);
        en_ram = 9'd0;
        training_flag = 1'b1;
        tick();
        training_flag = 1'b0;
        chk("zero_drop", 32'(drop_cnt), 32'd1);
        chk("zero_cnt", 32'(fifo_count), 32'd0);

        // stray ack with mem_req low
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_cnt", 32'(fifo_count), 32'd0);
        chk("stray_req", 32'(mem_req), 32'd0);

        // overflow from a clean reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        training_flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            en_ram = 9'(1 << i);
            state_plus1 = 18'(18'h100 + i);
            Q_new = 16'(16'h1000 + i);
            tick();
        end
        training_flag = 1'b0;
        en_ram = 9'd0;
        chk("ovf_cnt", 32'(fifo_count), 32'd4);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_bank", 32'(mem_bank), 32'd1);
        chk("ovf_addr", 32'(mem_addr), 32'h100);
        chk("ovf_wdata", 32'(mem_wdata), 32'h1000);

        // capture while full and popping on the same edge is dropped
        mem_ack = 1'b1;
        training_flag = 1'b1;
        en_ram = 9'b100000000;
        state_plus1 = 18'h3ABCD;
        Q_new = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        training_flag = 1'b0;
        en_ram = 9'd0;
        chk("fullpop_cnt", 32'(fifo_count), 32'd3);
        chk("fullpop_drop", 32'(drop_cnt), 32'd3);
        chk("fullpop_req", 32'(mem_req), 32'd0);
        tick();
        for (int i = 1; i < 4; i++) begin
            chk("drain_req", 32'(mem_req), 32'd1);
            chk("drain_bank", 32'(mem_bank), 32'(i + 1));
            chk("drain_addr", 32'(mem_addr), 32'(18'h100 + i));
            chk("drain_wdata", 32'(mem_wdata), 32'(16'h1000 + i));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            tick();
        end
        chk("drain_cnt", 32'(fifo_count), 32'd0);
        chk("drain_idle", 32'(mem_req), 32'd0);

        // read priority over two queued writes
        training_flag = 1'b1;
        en_ram = 9'b000000010;
        state_plus1 = 18'h00200;
        Q_new = 16'hAAAA;
        rd_req = 1'b1;
        rd_state = 18'h3FFFF;
        tick();
        rd_req = 1'b0;
        en_ram = 9'b000000100;
        state_plus1 = 18'h00201;
        Q_new = 16'hBBBB;
        chk("rp_busy", 32'(rd_busy), 32'd1);
        tick();
        training_flag = 1'b0;
        en_ram = 9'd0;
        chk("rp_cnt", 32'(fifo_count), 32'd2);
        chk("rp_we", 32'(mem_we), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            chk("rd_req_hi", 32'(mem_req), 32'd1);
            chk("rd_bank", 32'(mem_bank), 32'(k));
            chk("rd_addr", 32'(mem_addr), 32'h3FFFF);
            chk("rd_valid_lo", 32'(rd_valid), 32'd0);
            mem_rdata = 16'(k * 16'h0100);
            mem_ack = 1'b1;
            if (k == 3) begin
                rd_req = 1'b1;
                rd_state = 18'h12345;
            end
            tick();
            mem_ack = 1'b0;
            rd_req = 1'b0;
        end
        chk("rdone_valid", 32'(rd_valid), 32'd1);
        chk("rdone_req", 32'(mem_req), 32'd0);
        chk("rdone_busy", 32'(rd_busy), 32'd1);
        chk("rdone_q1", 32'(q_act1), 32'h0100);
        chk("rdone_q5", 32'(q_act5), 32'h0500);
        chk("rdone_q9", 32'(q_act9), 32'h0900);
        tick();
        chk("post_valid", 32'(rd_valid), 32'd0);
        chk("post_busy", 32'(rd_busy), 32'd0);
        tick();
        chk("wa_req", 32'(mem_req), 32'd1);
        chk("wa_we", 32'(mem_we), 32'd1);
        chk("wa_bank", 32'(mem_bank), 32'd2);
        chk("wa_addr", 32'(mem_addr), 32'h200);
        chk("wa_wdata", 32'(mem_wdata), 32'hAAAA);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("wb_bank", 32'(mem_bank), 32'd3);
        chk("wb_addr", 32'(mem_addr), 32'h201);
        chk("wb_wdata", 32'(mem_wdata), 32'hBBBB);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("wb_cnt", 32'(fifo_count), 32'd0);
        chk("hold_q3", 32'(q_act3), 32'h0300);
        chk("hold_q9", 32'(q_act9), 32'h0900);

        // reset in the middle of a read
        rd_req = 1'b1;
        rd_state = 18'h00ABC;
        tick();
        rd_req = 1'b0;
        chk("mr_req0", 32'(mem_req), 32'd0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            chk("mr_bank", 32'(mem_bank), 32'(k));
            mem_rdata = 16'(k * 16'h0011);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        chk("mr_q2", 32'(q_act2), 32'h0022);
        rst = 1'b1;
        mem_ack = 1'b1;
        training_flag = 1'b1;
        en_ram = 9'b000000001;
        rd_req = 1'b1;
        tick();
        rst = 1'b0;
        mem_ack = 1'b0;
        training_flag = 1'b0;
        en_ram = 9'd0;
        rd_req = 1'b0;
        chk("mr_rst_req", 32'(mem_req), 32'd0);
        chk("mr_rst_bank", 32'(mem_bank), 32'd0);
        chk("mr_rst_addr", 32'(mem_addr), 32'd0);
        chk("mr_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("mr_rst_q1", 32'(q_act1), 32'd0);
        chk("mr_rst_q9", 32'(q_act9), 32'd0);
        chk("mr_rst_busy", 32'(rd_busy), 32'd0);
        chk("mr_rst_cnt", 32'(fifo_count), 32'd0);
        chk("mr_rst_drop", 32'(drop_cnt), 32'd0);
        rd_req = 1'b1;
        rd_state = 18'h00DEF;
        tick();
        rd_req = 1'b0;
        tick();
        chk("mr_re_req", 32'(mem_req), 32'd1);
        chk("mr_re_we", 32'(mem_we), 32'd0);
        chk("mr_re_bank", 32'(mem_bank), 32'd1);
        chk("mr_re_addr", 32'(mem_addr), 32'h0DEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
